// File: rtl/pipe_reg_skid.sv
// ---------------------------------------------------------------------------
// pipe_reg_skid
//
// Pipeline register with a valid/ready handshake and a one-entry skid buffer.
// The main register M always drives out_data. The skid register S catches the
// word that arrives while the consumer is stalled. Both handshake outputs are
// decoded from the state flops only, so out_ready never reaches in_ready
// combinationally, and the stage still sustains one transfer per cycle.
//
// Parameters
//   WIDTH     payload width in bits (>= 1)
//   RESET_VAL value loaded into M and S on reset
//   CNT_W     stall counter width (>= 1)
//
// Ports
//   clock      in   rising-edge clock
//   clr_n      in   asynchronous active-low reset
//   flush      in   synchronous flush; empties the stage, highest priority
//   in_valid   in   producer has data
//   in_ready   out  stage can accept (state != FULL)
//   in_data    in   producer payload
//   out_valid  out  out_data holds valid data (state != EMPTY)
//   out_ready  in   consumer accepts
//   out_data   out  payload from the main register M
//   occupancy  out  entries held: 0, 1 or 2
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
// ---------------------------------------------------------------------------
module pipe_reg_skid #(
    parameter int unsigned             WIDTH     = 66,
    parameter logic [WIDTH-1:0]        RESET_VAL = '0,
    parameter int unsigned             CNT_W     = 16
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The state encoding is the occupancy value itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               pop;

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= EMPTY;
            m_q     <= RESET_VAL;
            s_q     <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;

        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != FULL);
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;

        if (flush) begin
            // Data registers hold; any word accepted this cycle is dropped.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        m_d     = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        m_d = in_data;
                    end else if (accept) begin
                        s_d     = in_data;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        m_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Counts regardless of flush and sticks at all-ones.
        if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign out_data  = m_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_reg_skid.md
# pipe_reg_skid

Parametrised pipeline register with a valid/ready handshake and a one-entry skid buffer. It generalises the plain enable/clear register bank to any width and adds backpressure, a flush, occupancy reporting and a saturating stall counter. It sits between datapath stages wherever a stage can stall. It sustains one transfer per cycle with no combinational path from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 66, payload width in bits (≥1)
- `RESET_VAL`, 0, value loaded into both data registers on reset
- `CNT_W`, 16, stall-counter width (≥1)

- `clock`  in  1  single clock, rising edge
- `clr_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous flush, highest priority
- `in_valid`  in  1  producer has data
- `in_ready`  out  1  block can accept
- `in_data`  in  WIDTH  producer payload
- `out_valid`  out  1  `out_data` holds valid data
- `out_ready`  in  1  consumer accepts
- `out_data`  out  WIDTH  payload (main register)
- `occupancy`  out  2  entries held: 0, 1 or 2
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles

## Operation
- Storage: main register `M` drives `out_data`; skid register `S` holds overflow.
- State machine, encoded by `occupancy`:
  - EMPTY = 0
  - ONE = 1 (`M` valid)
  - FULL = 2 (`M` and `S` valid)
- Derived outputs:
  - `out_valid` = (state ≠ EMPTY)
  - `in_ready` = (state ≠ FULL)
  - Both decode from state flops only.
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Transitions when `flush`=0:
  - EMPTY, accept: `M`←`in_data`, go to ONE.
  - ONE, accept & pop: `M`←`in_data`, stay in ONE.
  - ONE, accept only: `S`←`in_data`, go to FULL.
  - ONE, pop only: go to EMPTY.
  - FULL, pop: `M`←`S`, go to ONE. No accept is possible in FULL.
  - Any other case: hold.
- Flush (`flush`=1):
  - Next state is EMPTY.
  - Any accept in that cycle is discarded.
  - `M` and `S` hold their values.
  - A pop in that cycle is still a legal consumption.
- `out_data` while EMPTY shows the stale `M` value. Consumers must qualify it with `out_valid`.
- Data registers load only on the events above. No other writes.
- `stall_cnt`:
  - Increments each cycle with `out_valid & ~out_ready`.
  - Saturates at 2^CNT_W−1; never wraps.
  - Unaffected by `flush`; cleared only by reset.
- Payload order is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (`clr_n`=0, asynchronous, effective immediately):
  - State = EMPTY, so `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - `M`=`S`=RESET_VAL, `stall_cnt`=0.
- Reset mid-operation discards all held entries. Release is synchronous to `clock`; the first accept can occur on the first edge after deassertion.
- Latency: data accepted at edge k is on `out_data` with `out_valid`=1 after edge k, i.e. one cycle.
- Throughput: 1 transfer/cycle while `out_ready`=1.
- Backpressure: `in_ready` falls one cycle after the first unpopped accept beyond one entry, i.e. on entering FULL. The skid entry absorbs the in-flight word.
- Simultaneous `flush` and accept/pop: flush wins on state. The input word is lost.
- `occupancy` and `stall_cnt` are registered and update on the same edge as the state.

## Test plan
- **Reset:** assert `clr_n`=0 mid-FULL with WIDTH=66. Require:
  - `out_valid`=0, `in_ready`=1, `occupancy`=0 immediately.
  - `out_data`=RESET_VAL.
  - `stall_cnt`=0.
- **Streaming:** `out_ready`=1, push 0x1..0x8 on consecutive cycles. Require:
  - `out_data` = 0x1..0x8 one cycle after each accept.
  - `occupancy` stays 1; `in_ready` never drops.
- **Skid fill:** push 0xA then 0xB with `out_ready`=0. Require:
  - `occupancy`=2, `in_ready`=0, `out_data`=0xA.
  - `stall_cnt` increments each stalled cycle.
  - Raise `out_ready`: 0xA then 0xB pop in order, and `occupancy` goes 2→1→0.
- **Flush:** in FULL, assert `flush` with `in_valid`=1, `in_data`=0xC. Require:
  - Next cycle `occupancy`=0, `out_valid`=0.
  - 0xC never appears on the output.
  - `stall_cnt` unchanged by the flush.
- **Saturation:** CNT_W=3, hold `out_valid`=1 with `out_ready`=0 for 10 cycles. Require `stall_cnt`=7 and held.
- **Random:** random `in_valid`/`out_ready` for 10k cycles against a scoreboard. Require:
  - No loss, duplication or reorder.
  - `in_ready`=0 only when `occupancy`=2.
